multiword_add_ctrl: RTL and testbench
=====================================

// Module: multiword_add_ctrl
// PURPOSE
//   Sequencer that performs one WORDS*W-bit addition by time-multiplexing a single
//   external W-bit combinational adder (ripple, lookahead or carry-select).
//   Feeds one slice per cycle, LSW first, and registers each carry into the next cin.
//   Sits between a requester (start/done handshake) and the 16-bit adder instance.
// PARAMETERS
//   W      16  slice width; must match the external adder width
//   WORDS  4   slices per operation (>=2); operand width = W*WORDS
// PORTS
//   Clk       in   1        system clock, rising edge
//   Reset_n   in   1        asynchronous, active-low reset
//   start     in   1        request; sampled only in IDLE
//   A_in      in   W*WORDS  operand A; latched on accepted start
//   B_in      in   W*WORDS  operand B; latched on accepted start
//   cin_in    in   1        carry-in to slice 0; latched on accepted start
//   busy      out  1        high in RUN and DONE
//   done      out  1        one-cycle pulse: Sum/Cout valid
//   Sum       out  W*WORDS  result register
//   Cout      out  1        carry-out of the top slice
//   add_A     out  W        to adder A
//   add_B     out  W        to adder B
//   add_cin   out  1        to adder cin
//   add_S     in   W        from adder S (combinational)
//   add_cout  in   1        from adder cout (combinational)
// BEHAVIOUR
//   - Reset (Reset_n=0, async): state=IDLE, idx=0, carry=0; operand regs, Sum, Cout
//     cleared; busy=done=0; add_A=add_B=0, add_cin=0. Reset mid-operation aborts the
//     operation with no done pulse.
//   - FSM states IDLE, RUN, DONE.
//     IDLE -> RUN on start=1: latch A_in, B_in, cin_in; idx<=0; carry<=cin_in.
//     RUN, each cycle: add_A=A[idx*W+:W], add_B=B[idx*W+:W], add_cin=carry.
//       At the edge: Sum[idx*W+:W]<=add_S; carry<=add_cout; idx<=idx+1.
//       If idx==WORDS-1, also Cout<=add_cout and go to DONE.
//     DONE: done=1 for exactly one cycle, then IDLE.
//   - Latency: start sampled at edge 0; slices written at edges 1..WORDS;
//     done is high during the cycle after edge WORDS. Minimum start-to-start
//     spacing is WORDS+2 cycles.
//   - start is ignored in RUN and DONE; operand inputs may change freely once
//     latched.
//   - Outside RUN, add_A, add_B and add_cin are driven to 0.
//   - Sum and Cout hold their values until the next accepted start. During RUN,
//     Sum is partially updated; it is valid only while done is high or in IDLE
//     after a done.
//   - Arithmetic: {Cout,Sum} = A + B + cin, modulo 2^(W*WORDS+1). The result is
//     exact provided the external adder is correct.
//   - idx is $clog2(WORDS) bits wide. idx never wraps during RUN; it is reset to 0
//     on each accepted start.
// TESTING (W=16, WORDS=4, bound to ripple_adder; repeat with lookahead/select)
//   1 A=0x0000_0000_0000_FFFF, B=0x1, cin=0
//     -> Sum=0x0000_0000_0001_0000, Cout=0, done 5 cycles after start edge.
//   2 A=0xFFFF_FFFF_FFFF_FFFF, B=0x0, cin=1
//     -> Sum=0, Cout=1; add_cin=1 in every RUN cycle (carry ripples all slices).
//   3 A=0xFFFF_FFFF_FFFF_FF00, B=0xFFFF_FFFF_FFFF_FFFF, cin=1
//     -> Sum=0xFFFF_FFFF_FFFF_FF00, Cout=1.
//   4 Start case 1, then pulse start with case 2 operands during RUN
//     -> ignored; result is still case 1; exactly one done pulse.
//   5 Start case 2, drop Reset_n in the 2nd RUN cycle
//     -> busy, Sum, Cout, add_* all 0 immediately; no done.
//     Release reset, run case 3 -> correct result.
//   6 start held high with 1000 random operands, checked against a reference
//     model at each done -> 0 mismatches; done spacing is exactly 6 cycles.

Source files
------------

// File: rtl/multiword_add_ctrl.sv
// Multi-word adder sequencer: one WORDS*W-bit add through a single external W-bit
// combinational adder, one slice per cycle LSW first, carry registered between slices.
module multiword_add_ctrl #(
    parameter int W     = 16,
    parameter int WORDS = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic [W*WORDS-1:0] A_in,
    input  logic [W*WORDS-1:0] B_in,
    input  logic               cin_in,
    output logic               busy,
    output logic               done,
    output logic [W*WORDS-1:0] Sum,
    output logic               Cout,
    output logic [W-1:0]       add_A,
    output logic [W-1:0]       add_B,
    output logic               add_cin,
    input  logic [W-1:0]       add_S,
    input  logic               add_cout
);

    localparam int N     = W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;

    // Adder inputs are gated so the shared adder sees zeros outside RUN.
    always_comb begin
        add_A   = '0;
        add_B   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_A   = a_q[idx*W +: W];
            add_B   = b_q[idx*W +: W];
            add_cin = carry;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= A_in;
                        b_q   <= B_in;
                        carry <= cin_in;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    Sum[idx*W +: W] <= add_S;
                    carry           <= add_cout;
                    // idx parks at 0 after the top slice instead of wrapping.
                    if (idx == IDX_W'(WORDS-1)) begin
                        Cout  <= add_cout;
                        idx   <= '0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Bench for multiword_add_ctrl: behavioural 16-bit adder, scoreboard queue of
// expected {Cout,Sum} pushed at start and popped on each done pulse.
module tb_multiword_add_ctrl;

    localparam int W     = 16;
    localparam int WORDS = 4;
    localparam int N     = W * WORDS;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] A_in = '0;
    logic [N-1:0] B_in = '0;
    logic         cin_in = 1'b0;
    logic         busy, done, Cout, add_cin, add_cout;
    logic [N-1:0] Sum;
    logic [W-1:0] add_A, add_B, add_S;

    int err_cnt = 0;
    int chk_cnt = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_done_cyc = -1;
    bit spacing_on = 1'b0;
    logic [N:0] exp_q[$];

    always #5 Clk = ~Clk;

    assign {add_cout, add_S} = {1'b0, add_A} + {1'b0, add_B} + {{W{1'b0}}, add_cin};

    multiword_add_ctrl #(.W(W), .WORDS(WORDS)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start),
        .A_in(A_in), .B_in(B_in), .cin_in(cin_in),
        .busy(busy), .done(done), .Sum(Sum), .Cout(Cout),
        .add_A(add_A), .add_B(add_B), .add_cin(add_cin),
        .add_S(add_S), .add_cout(add_cout)
    );

    task automatic chk(input string tag, input logic [N:0] act, input logic [N:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic c);
        return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
    endfunction

    always @(posedge Clk) cyc++;

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) chk("spurious_done", 1, 0);
            else chk("result", {Cout, Sum}, exp_q.pop_front());
            if (spacing_on && last_done_cyc >= 0) chk("spacing", cyc - last_done_cyc, 6);
            last_done_cyc = cyc;
        end
    end

    // One operation from idle; checks done latency (high in the cycle after the
    // WORDS-th edge following the accept edge) and optionally add_cin in RUN.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                          input bit cin_all);
        int k;
        @(negedge Clk);
        A_in = a; B_in = b; cin_in = c; start = 1'b1;
        exp_q.push_back(ref_add(a, b, c));
        @(posedge Clk);
        #1 start = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge Clk);
            if (done) break;
            if (cin_all) chk("add_cin_run", add_cin, 1);
            @(posedge Clk);
            k++;
        end
        if (k >= 20) chk("done_timeout", 0, 1);
        else chk("latency", k, WORDS);
        @(negedge Clk);
        @(negedge Clk);
        chk("sum_hold", {Cout, Sum}, ref_add(a, b, c));
        chk("idle_busy", busy, 0);
    endtask

    localparam logic [N-1:0] C1A = 64'h0000_0000_0000_FFFF, C1B = 64'h1;
    localparam logic [N-1:0] C2A = 64'hFFFF_FFFF_FFFF_FFFF, C2B = 64'h0;
    localparam logic [N-1:0] C3A = 64'hFFFF_FFFF_FFFF_FF00, C3B = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        int d0;
        int k;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", {Cout, Sum}, 0);
        chk("rst_addA", add_A, 0);
        chk("rst_addB", add_B, 0);
        chk("rst_addcin", add_cin, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        run_op(C1A, C1B, 1'b0, 1'b0);
        chk("case1_exact", {Cout, Sum}, {1'b0, 64'h0000_0000_0001_0000});
        run_op(C2A, C2B, 1'b1, 1'b1);
        chk("case2_exact", {Cout, Sum}, {1'b1, 64'h0});
        run_op(C3A, C3B, 1'b1, 1'b0);
        chk("case3_exact", {Cout, Sum}, {1'b1, 64'hFFFF_FFFF_FFFF_FF00});

        // Start pulsed mid-RUN with different operands must be ignored.
        d0 = done_cnt;
        @(negedge Clk);
        A_in = C1A; B_in = C1B; cin_in = 1'b0; start = 1'b1;
        exp_q.push_back(ref_add(C1A, C1B, 1'b0));
        @(posedge Clk);
        #1 start = 1'b0;
        @(negedge Clk);
        A_in = C2A; B_in = C2B; cin_in = 1'b1; start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
        repeat (14) @(negedge Clk);
        chk("ignore_done_cnt", done_cnt - d0, 1);
        chk("ignore_result", {Cout, Sum}, ref_add(C1A, C1B, 1'b0));

        // Reset in the 2nd RUN cycle aborts without a done pulse.
        d0 = done_cnt;
        @(negedge Clk);
        A_in = C2A; B_in = C2B; cin_in = 1'b1; start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_sum", {Cout, Sum}, 0);
        chk("abort_add", {add_cin, add_A, add_B}, 0);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (8) @(negedge Clk);
        chk("abort_no_done", done_cnt - d0, 0);
        run_op(C3A, C3B, 1'b1, 1'b0);

        // Start held high: back-to-back random operations every 6 cycles.
        last_done_cyc = -1;
        spacing_on = 1'b1;
        @(negedge Clk);
        for (int i = 0; i < 1000; i++) begin
            A_in = {$urandom, $urandom};
            B_in = {$urandom, $urandom};
            cin_in = 1'($urandom);
            start = 1'b1;
            exp_q.push_back(ref_add(A_in, B_in, cin_in));
            repeat (6) @(posedge Clk);
            @(negedge Clk);
        end
        start = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(negedge Clk);
            k++;
        end
        chk("drain", exp_q.size(), 0);
        spacing_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
